// File: rtl/sr_bank_writer.sv
// sr_bank_writer: masked SR-bank write via set/reset pulses, readback check, bounded retry.
// Latency PULSE+3 cycles (no-op write 2, +PULSE+2 per retry); req_ready high only in IDLE.
module sr_bank_writer #(
  parameter int WIDTH     = 8,
  parameter int PULSE     = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PW = (PULSE > 1) ? $clog2(PULSE) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] mask;
  } req_t;

  state_t           state, state_nxt;
  req_t             req_q, req_nxt;
  logic [PW-1:0]    pulse_cnt, pulse_nxt;
  logic [RW-1:0]    retry_cnt, retry_nxt;
  logic [WIDTH-1:0] s_nxt, r_nxt;
  logic             done_nxt, err_nxt;

  logic             accept;
  logic [WIDTH-1:0] acc_set, acc_rst;
  logic [WIDTH-1:0] chk_set, chk_rst;
  logic [WIDTH-1:0] mismatch;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;

  // Excitation: set only bits that must rise, reset only bits that must fall.
  // data and ~data gate s and r, so they can never overlap.
  assign acc_set  = req_mask & req_data & ~q;
  assign acc_rst  = req_mask & ~req_data & q;
  assign chk_set  = req_q.mask & req_q.data & ~q;
  assign chk_rst  = req_q.mask & ~req_q.data & q;
  assign mismatch = (q ^ req_q.data) & req_q.mask;

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    pulse_nxt = pulse_cnt;
    retry_nxt = retry_cnt;
    s_nxt     = '0;
    r_nxt     = '0;
    done_nxt  = 1'b0;
    err_nxt   = err;

    unique case (state)
      IDLE: begin
        if (accept) begin
          req_nxt.data = req_data;
          req_nxt.mask = req_mask;
          retry_nxt    = '0;
          pulse_nxt    = '0;
          err_nxt      = 1'b0;
          s_nxt        = acc_set;
          r_nxt        = acc_rst;
          state_nxt    = ((acc_set | acc_rst) == '0) ? CHECK : DRIVE;
        end
      end

      DRIVE: begin
        if (pulse_cnt == PW'(PULSE - 1)) begin
          state_nxt = SETTLE;
        end else begin
          pulse_nxt = pulse_cnt + PW'(1);
          s_nxt     = s;
          r_nxt     = r;
        end
      end

      SETTLE: begin
        state_nxt = CHECK;
      end

      CHECK: begin
        if (mismatch == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b0;
        end else if (retry_cnt < RW'(MAX_RETRY)) begin
          retry_nxt = retry_cnt + RW'(1);
          pulse_nxt = '0;
          s_nxt     = chk_set;
          r_nxt     = chk_rst;
          state_nxt = DRIVE;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      pulse_cnt <= '0;
      retry_cnt <= '0;
      s         <= '0;
      r         <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_q     <= req_nxt;
      pulse_cnt <= pulse_nxt;
      retry_cnt <= retry_nxt;
      s         <= s_nxt;
      r         <= r_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Bench for sr_bank_writer: behavioural SR bank with stuck-at-0 injection,
// scoreboard of expected completions checked against done pulses.
module tb_sr_bank_writer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] req_mask = '0;
  logic [W-1:0] q = '0;
  logic [W-1:0] s, r;
  logic         busy, done, err;

  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] q_val = '0;
  logic         q_load = 1'b0;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;

  typedef struct {
    logic         err;
    logic [W-1:0] q;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  sr_bank_writer #(.WIDTH(W), .PULSE(2), .MAX_RETRY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mask(req_mask), .q(q), .s(s), .r(r),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // SR bank: q updates on the clock edge, stuck-at-0 bits never rise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (q_load) q <= q_val & ~stuck0;
    else        q <= ((q | s) & ~r) & ~stuck0;
  end

  task automatic set_q(input logic [W-1:0] v);
    @(negedge clk);
    q_val  = v;
    q_load = 1'b1;
    @(negedge clk);
    q_load = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if ((s & r) !== '0) begin
        errors++;
        $display("FAIL sr_overlap cyc=%0d s=%h r=%h required s&r=00", cyc, s, r);
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cyc=%0d got done=1 required no done", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL done_latency got cyc=%0d required cyc=%0d", cyc, e.cyc);
          end
          checks++;
          if (err !== e.err) begin
            errors++;
            $display("FAIL done_err cyc=%0d got %b required %b", cyc, err, e.err);
          end
          checks++;
          if (q !== e.q) begin
            errors++;
            $display("FAIL done_q cyc=%0d got %h required %h", cyc, q, e.q);
          end
        end
      end
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_done got none by cyc=%0d required at cyc=%0d", cyc, sb[0].cyc);
        e = sb.pop_front();
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({s, r, done, err, busy, req_ready} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got s=%h r=%h done=%b err=%b busy=%b rdy=%b required 00 00 0 0 0 1",
               s, r, done, err, busy, req_ready);
    end
    set_q(8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    set_q(8'h0F);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready got %b required 1", req_ready);
    end
    req_valid = 1'b1; req_data = 8'hA5; req_mask = 8'hFF;
    sb.push_back('{1'b0, 8'hA5, cyc + 5});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      checks++;
      if (k <= 2 && (s !== 8'hA0 || r !== 8'h0A)) begin
        errors++;
        $display("FAIL basic_drive k=%0d got s=%h r=%h required A0 0A", k, s, r);
      end else if (k > 2 && (s !== 8'h00 || r !== 8'h00)) begin
        errors++;
        $display("FAIL basic_idle_sr k=%0d got s=%h r=%h required 00 00", k, s, r);
      end
      checks++;
      if (busy !== (k <= 4)) begin
        errors++;
        $display("FAIL basic_busy k=%0d got %b required %b", k, busy, (k <= 4));
      end
    end
  endtask

  task automatic test_mask();
    set_q(8'h3C);
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'hFF; req_mask = 8'h0F;
    sb.push_back('{1'b0, 8'h3F, cyc + 5});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      checks++;
      if (s !== ((k <= 2) ? 8'h03 : 8'h00) || r !== 8'h00) begin
        errors++;
        $display("FAIL mask_drive k=%0d got s=%h r=%h required %h 00", k, s, r, (k <= 2) ? 8'h03 : 8'h00);
      end
    end
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'hFF; req_mask = 8'h00;
    sb.push_back('{1'b0, 8'h3F, cyc + 2});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      checks++;
      if (s !== 8'h00 || r !== 8'h00 || busy !== (k == 1)) begin
        errors++;
        $display("FAIL nochange k=%0d got s=%h r=%h busy=%b required 00 00 %b", k, s, r, busy, (k == 1));
      end
    end
  endtask

  task automatic test_retry();
    logic [W-1:0] exp_s;
    stuck0 = 8'h01;
    set_q(8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'h01; req_mask = 8'h01;
    sb.push_back('{1'b1, 8'h00, cyc + 9});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      exp_s = (k == 1 || k == 2 || k == 5 || k == 6) ? 8'h01 : 8'h00;
      checks++;
      if (s !== exp_s || r !== 8'h00) begin
        errors++;
        $display("FAIL retry_drive k=%0d got s=%h r=%h required %h 00", k, s, r, exp_s);
      end
      checks++;
      if (busy !== (k <= 8)) begin
        errors++;
        $display("FAIL retry_busy k=%0d got %b required %b", k, busy, (k <= 8));
      end
    end
    stuck0 = 8'h00;
  endtask

  task automatic test_rst_mid();
    set_q(8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'h33; req_mask = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s !== 8'h33 || r !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_drive got s=%h r=%h required 33 00", s, r);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (s !== 8'h00 || r !== 8'h00 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got s=%h r=%h busy=%b rdy=%b done=%b required 00 00 0 1 0",
               s, r, busy, req_ready, done);
    end
    @(negedge clk);
    rst = 1'b0;
    // bank holds 0x33 from the abandoned pulse
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'hC3; req_mask = 8'hFF;
    sb.push_back('{1'b0, 8'hC3, cyc + 5});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k <= 2) begin
        checks++;
        if (s !== 8'hC0 || r !== 8'h30) begin
          errors++;
          $display("FAIL rstmid_next k=%0d got s=%h r=%h required C0 30", k, s, r);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    set_q(8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'hA5; req_mask = 8'hFF;
    sb.push_back('{1'b0, 8'hA5, cyc + 5});
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) req_data = 8'h5A;
      if (k == 5) begin
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done_cycle got rdy=%b done=%b err=%b required 1 1 0", req_ready, done, err);
        end
        sb.push_back('{1'b0, 8'h5A, cyc + 5});
      end
      if (k == 6) begin
        req_valid = 1'b0;
        checks++;
        if (s !== 8'h5A || r !== 8'hA5 || busy !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second got s=%h r=%h busy=%b err=%b required 5A A5 1 0", s, r, busy, err);
        end
      end
      if (k == 11) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_final_busy got %b required 0", busy);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_mask();
    test_retry();
    test_rst_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
